// File: rtl/sram_ctl_pkg.sv
// Shared definitions for the SRAM-side packet buffers: beat flag positions
// (relative to the top of the payload) and the write-side FSM encoding.
package sram_ctl_pkg;

    localparam int FLAG_EOP = 0;
    localparam int FLAG_SOP = 1;
    localparam int FLAG_W   = 2;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_FILL    = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM for pkt_fifo: synchronous write, registered read port.
// The read register holds its value until the next read enable.
module fifo_mem #(
    parameter  int WIDTH  = 258,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array is deliberately not reset so it maps onto RAM
    // macros; only locations behind commit_ptr are ever read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/pkt_fifo.sv
// Store-and-forward packet FIFO: beats become visible to the reader only once
// their packet is committed by eop; oversize or aborted packets are rolled back.
module pkt_fifo
    import sram_ctl_pkg::*;
#(
    parameter  int DATA_WIDTH = 256,
    parameter  int DEPTH      = 16,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_vld,
    input  logic                  wr_sop,
    input  logic                  wr_eop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  read,
    output logic                  sop,
    output logic                  eop,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic                  full,
    output logic                  drop
);

    localparam int                WORD_W  = DATA_WIDTH + FLAG_W;
    localparam logic [ADDR_W:0]   DEPTH_P = (ADDR_W + 1)'(DEPTH);

    logic [ADDR_W:0]   rd_ptr, wr_ptr, commit_ptr;
    logic [ADDR_W:0]   wr_ptr_nxt, commit_ptr_nxt, wr_addr;
    wr_state_e         state, state_nxt;
    logic              mem_we, commit, drop_nxt;
    logic [WORD_W-1:0] mem_wdata, mem_rdata;
    logic              readable, pop, pop_eop;
    logic [DEPTH-1:0]  eop_map;

    assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
    assign readable = rd_ptr != commit_ptr;
    assign pop      = read && readable;
    // eop flags mirrored in flops so pkt_cnt drops on the same edge the last beat is popped
    assign pop_eop  = eop_map[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WR_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can infer a latch.
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        wr_addr        = wr_ptr;
        mem_we         = 1'b0;
        commit         = 1'b0;
        drop_nxt       = 1'b0;
        mem_wdata      = '0;
        mem_wdata[DATA_WIDTH-1:0]       = wr_data;
        mem_wdata[DATA_WIDTH+FLAG_SOP]  = wr_sop;
        mem_wdata[DATA_WIDTH+FLAG_EOP]  = wr_eop;

        case (state)
            WR_IDLE: begin
                if (wr_vld && wr_sop) begin
                    if (full) begin
                        drop_nxt = 1'b1;
                        if (!wr_eop) state_nxt = WR_DISCARD;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_ptr + 1'b1;
                        if (wr_eop) begin
                            commit         = 1'b1;
                            commit_ptr_nxt = wr_ptr + 1'b1;
                        end else begin
                            state_nxt = WR_FILL;
                        end
                    end
                end
            end
            WR_FILL: begin
                if (wr_vld) begin
                    if (full) begin
                        wr_ptr_nxt = commit_ptr;
                        drop_nxt   = 1'b1;
                        state_nxt  = wr_eop ? WR_IDLE : WR_DISCARD;
                    end else begin
                        // a fresh sop restarts the packet over the abandoned beats
                        if (wr_sop) begin
                            drop_nxt = 1'b1;
                            wr_addr  = commit_ptr;
                        end
                        mem_we     = 1'b1;
                        wr_ptr_nxt = wr_addr + 1'b1;
                        if (wr_eop) begin
                            commit         = 1'b1;
                            commit_ptr_nxt = wr_addr + 1'b1;
                            state_nxt      = WR_IDLE;
                        end
                    end
                end
            end
            WR_DISCARD: begin
                if (wr_vld && wr_eop) state_nxt = WR_IDLE;
            end
            default: state_nxt = WR_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            pkt_cnt    <= '0;
            vld        <= 1'b0;
            drop       <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            vld        <= pop;
            drop       <= drop_nxt;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({commit, pop && pop_eop})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) eop_map[wr_addr[ADDR_W-1:0]] <= wr_eop;
    end

    fifo_mem #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_addr[ADDR_W-1:0]),
        .wdata (mem_wdata),
        .re    (pop),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_rdata)
    );

    assign out_data = mem_rdata[DATA_WIDTH-1:0];
    assign sop      = vld && mem_rdata[DATA_WIDTH+FLAG_SOP];
    assign eop      = vld && mem_rdata[DATA_WIDTH+FLAG_EOP];

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo: expected beats are queued as packets are written
// and popped as the FIFO presents them.
module tb_pkt_fifo;

    localparam int DW    = 256;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            wr_vld = 1'b0, wr_sop = 1'b0, wr_eop = 1'b0;
    logic [DW-1:0]   wr_data = '0;
    logic            read = 1'b0;
    logic            sop, eop, vld, full, drop;
    logic [DW-1:0]   out_data;
    logic [CNT_W-1:0] pkt_cnt;

    logic [DW+1:0]   sb[$];
    int n_checks = 0, n_pass = 0;
    int vld_seen = 0, drop_seen = 0, drop_beat = 0, cur_beat = 0, max_cnt = 0;
    bit full_seen = 1'b0;

    always #5 clk = ~clk;

    pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_data(wr_data), .read(read), .sop(sop), .eop(eop), .vld(vld),
        .out_data(out_data), .pkt_cnt(pkt_cnt), .full(full), .drop(drop)
    );

    task automatic check(input string tag, input logic [DW+1:0] obs, input logic [DW+1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mk(input int base, input int i);
        logic [31:0] w;
        w = 32'(base * 256 + i);
        return {8{w}};
    endfunction

    // advance one clock and observe outputs 1 ns after the edge
    task automatic tick();
        logic [DW+1:0] exp;
        @(posedge clk);
        #1;
        if (vld) begin
            vld_seen++;
            check("beat_pending", (DW+2)'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("beat", {sop, eop, out_data}, exp);
            end
        end else begin
            check("flags_idle", {sop, eop}, 0);
        end
        if (drop) begin
            drop_seen++;
            drop_beat = cur_beat;
        end
        if (int'(pkt_cnt) > max_cnt) max_cnt = int'(pkt_cnt);
        if (full) full_seen = 1'b1;
    endtask

    task automatic send_pkt(input int n, input int base, input bit with_eop, input bit push);
        for (int i = 0; i < n; i++) begin
            wr_vld   = 1'b1;
            wr_sop   = (i == 0);
            wr_eop   = with_eop && (i == n - 1);
            wr_data  = mk(base, i);
            cur_beat = i + 1;
            if (push) sb.push_back({wr_sop, wr_eop, wr_data});
            tick();
        end
        wr_vld = 1'b0;
        wr_sop = 1'b0;
        wr_eop = 1'b0;
    endtask

    task automatic rd_n(input int n);
        read = 1'b1;
        repeat (n) tick();
        read = 1'b0;
    endtask

    initial begin
        int v0, d0;

        // reset state
        repeat (3) tick();
        check("rst_outputs", {sop, eop, vld, full, drop}, 0);
        check("rst_data", out_data, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // four-beat packet, then read it back
        send_pkt(4, 1, 1'b1, 1'b1);
        check("t2_pkt_cnt_1", pkt_cnt, 1);
        v0 = vld_seen;
        rd_n(3);
        check("t2_pkt_cnt_before_d", pkt_cnt, 1);
        rd_n(1);
        check("t2_eop_on_d", {sop, eop}, 2'b01);
        check("t2_pkt_cnt_0", pkt_cnt, 0);
        tick();
        check("t2_vld_beats", vld_seen - v0, 4);

        // single-beat packet
        wr_vld = 1'b1; wr_sop = 1'b1; wr_eop = 1'b1; wr_data = DW'('h5A);
        sb.push_back({2'b11, DW'('h5A)});
        tick();
        wr_vld = 1'b0; wr_sop = 1'b0; wr_eop = 1'b0;
        check("t3_pkt_cnt", pkt_cnt, 1);
        rd_n(1);
        check("t3_out", {vld, sop, eop, out_data}, {3'b111, DW'('h5A)});
        tick();
        check("t3_pkt_cnt_0", pkt_cnt, 0);

        // oversize packet: 20 beats into 16 entries
        d0 = drop_seen; v0 = vld_seen; full_seen = 1'b0;
        send_pkt(20, 4, 1'b1, 1'b0);
        tick();
        check("t4_drop_once", drop_seen - d0, 1);
        check("t4_drop_beat", drop_beat, 17);
        check("t4_full_seen", full_seen, 1);
        check("t4_full_after", full, 0);
        check("t4_pkt_cnt", pkt_cnt, 0);
        rd_n(1);
        tick();
        check("t4_no_vld", vld_seen - v0, 0);

        // sop arrives at beat 3 of an open packet
        d0 = drop_seen; v0 = vld_seen;
        send_pkt(2, 5, 1'b0, 1'b0);
        send_pkt(3, 6, 1'b1, 1'b1);
        tick();
        check("t5_drop_once", drop_seen - d0, 1);
        check("t5_pkt_cnt", pkt_cnt, 1);
        rd_n(3);
        tick();
        check("t5_vld_beats", vld_seen - v0, 3);
        check("t5_pkt_cnt_0", pkt_cnt, 0);

        // streaming 2-beat packets with the reader always on
        d0 = drop_seen; v0 = vld_seen; max_cnt = 0;
        read = 1'b1;
        for (int p = 0; p < 50; p++) send_pkt(2, 16 + p, 1'b1, 1'b1);
        repeat (4) tick();
        read = 1'b0;
        tick();
        check("t6_no_drop", drop_seen - d0, 0);
        check("t6_vld_beats", vld_seen - v0, 100);
        check("t6_max_cnt", (DW+2)'(max_cnt <= 8), 1);
        check("t6_sb_empty", sb.size(), 0);

        // reset in the middle of a packet while a beat is being presented
        send_pkt(2, 80, 1'b1, 1'b1);
        send_pkt(3, 81, 1'b0, 1'b0);
        rd_n(1);
        check("t1_pre_pkt_cnt", pkt_cnt, 1);
        #3 rst = 1'b0;
        #1;
        check("t1_outputs", {sop, eop, vld, full, drop}, 0);
        check("t1_data", out_data, 0);
        check("t1_pkt_cnt", pkt_cnt, 0);
        sb.delete();
        tick();
        @(negedge clk);
        rst = 1'b1;
        v0 = vld_seen;
        send_pkt(2, 90, 1'b1, 1'b1);
        check("t1_next_pkt_cnt", pkt_cnt, 1);
        rd_n(2);
        tick();
        check("t1_next_beats", vld_seen - v0, 2);
        check("t1_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
